ring_mem_sched: RTL and testbench

RING_MEM_SCHED -- requirements
Module: ring_mem_sched

---
 rtl/ring_pkg.sv | 22 ++
 rtl/ring_mem_sched_if.sv | 39 +++
 rtl/ring_wd_assembler.sv | 56 +++++
 rtl/ring_mem_sched.sv | 133 +++++++++++++
 tb/tb_ring_mem_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring memory scheduler.
//   - ring slot type codes
//   - scheduler FSM state enum
//   - type remap helper for the drain path
package ring_pkg;

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;
  localparam logic [3:0] SLOT_AREQ  = 4'd5;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  typedef enum logic [2:0] {
    IDLE, SEND_TOKEN, WAIT_TOKEN, WAIT_DATA, WAIT_Q, DRAIN
  } sched_state_t;

  // Address slots from remap-enabled queues go back on the ring as requests.
  function automatic logic [3:0] remap_type(input logic [3:0] t, input logic en);
    return (en && t == SLOT_ADDR) ? SLOT_AREQ : t;
  endfunction

endpackage

// File: rtl/ring_mem_sched_if.sv
// Bus bundle for ring_mem_sched: ring in/out slots, drain-queue handshake
// and downstream write-data queue signals.
//   slave  : the scheduler side
//   master : the ring / queue / memory environment side
interface ring_mem_sched_if #(
  parameter int W         = 32,
  parameter int NQ        = 2,
  parameter int WPL       = 4,
  parameter int WDQ_DEPTH = 1024
);
  localparam int CW = $clog2(WDQ_DEPTH + 1);

  logic [W-1:0]        ringIn;
  logic [3:0]          slotTypeIn;
  logic [3:0]          srcDestIn;
  logic [W-1:0]        ringOut;
  logic [3:0]          slotTypeOut;
  logic [3:0]          srcDestOut;
  logic                inhibit;
  logic [NQ-1:0]       qEmpty;
  logic [NQ-1:0]       qWr;
  logic [NQ*(W+8)-1:0] qData;
  logic [NQ-1:0]       qRd;
  logic                wdWr;
  logic [WPL*W-1:0]    wdData;
  logic                wdRd;
  logic [CW-1:0]       wdqCount;
  logic                wdqAlmostFull;

  modport slave (
    input  ringIn, slotTypeIn, srcDestIn, inhibit, qEmpty, qWr, qData, wdRd,
    output ringOut, slotTypeOut, srcDestOut, qRd, wdWr, wdData, wdqCount, wdqAlmostFull
  );

  modport master (
    output ringIn, slotTypeIn, srcDestIn, inhibit, qEmpty, qWr, qData, wdRd,
    input  ringOut, slotTypeOut, srcDestOut, qRd, wdWr, wdData, wdqCount, wdqAlmostFull
  );
endinterface

// File: rtl/ring_wd_assembler.sv
// Collects WriteData ring words into WPL-word lines and tracks occupancy of
// the downstream write-data queue.
//   word_valid/word : one ring word per WriteData slot
//   wd_wr/wd_data   : one-cycle line push, word 0 in LSBs
//   wd_rd           : downstream pop
//   wdq_count       : saturating occupancy count (0..WDQ_DEPTH)
module ring_wd_assembler #(
  parameter int W         = 32,
  parameter int WPL       = 4,
  parameter int WDQ_DEPTH = 1024,
  localparam int CW       = $clog2(WDQ_DEPTH + 1),
  localparam int PW       = (WPL > 1) ? $clog2(WPL) : 1
)(
  input  logic             clock,
  input  logic             resetB,
  input  logic             word_valid,
  input  logic [W-1:0]     word,
  input  logic             wd_rd,
  output logic             wd_wr,
  output logic [WPL*W-1:0] wd_data,
  output logic [CW-1:0]    wdq_count
);

  logic [WPL-1:0][W-1:0] words;
  logic [PW-1:0]         wcnt;
  logic                  last;

  assign last    = (int'(wcnt) == WPL - 1);
  assign wd_data = words;

  // Push fires the cycle after the last word lands, so the whole line is
  // visible while wd_wr is high even if the next line starts immediately.
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      words <= '0;
      wcnt  <= '0;
      wd_wr <= 1'b0;
    end else begin
      wd_wr <= word_valid && last;
      if (word_valid) begin
        words[wcnt] <= word;
        wcnt        <= last ? '0 : wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB)
      wdq_count <= '0;
    else if (wd_wr && !wd_rd && int'(wdq_count) < WDQ_DEPTH)
      wdq_count <= wdq_count + 1'b1;
    else if (!wd_wr && wd_rd && wdq_count != '0)
      wdq_count <= wdq_count - 1'b1;
  end

endmodule

// File: rtl/ring_mem_sched.sv
// Ring memory scheduler: issues tokens onto the ring, waits out the returned
// token's burst, then drains the per-queue slots back onto the ring. WriteData
// slots seen on the ring are assembled into lines for the write-data queue.
// Ports: clock, resetB (async, active low), bus (ring_mem_sched_if.slave).
// Build option: RING_MEM_SCHED_RR_EN selects round-robin drain grant;
// otherwise the lowest-index non-empty queue wins.
module ring_mem_sched
  import ring_pkg::*;
#(
  parameter int            W          = 32,
  parameter int            NQ         = 2,
  parameter int            WPL        = 4,
  parameter int            WDQ_DEPTH  = 1024,
  parameter int            WDQ_THRESH = 900,
  parameter logic [NQ-1:0] REMAP_MASK = NQ'(1)
)(
  input logic             clock,
  input logic             resetB,
  ring_mem_sched_if.slave bus
);

  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int EW = W + 8;

  sched_state_t  state;
  logic [7:0]    burst_cnt;
  logic [NQ-1:0] loaded;
  logic          go;
  logic          gnt_ok;
  logic [QW-1:0] gnt, gidx, rr;
  logic [EW-1:0] head;
  logic          unused_src;

  assign unused_src = ^bus.srcDestIn;
  assign go         = ~bus.inhibit & ~bus.wdqAlmostFull;

  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB)
      burst_cnt <= '0;
    else if (bus.slotTypeIn == SLOT_TOKEN)
      burst_cnt <= bus.ringIn[7:0];
    else if (burst_cnt != '0)
      burst_cnt <= burst_cnt - 1'b1;
  end

  // A queue written during the burst may not show non-empty yet; remember it
  // so WAIT_Q can hold off until the FIFO catches up. Pop clears over push.
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) loaded <= '0;
    else         loaded <= (loaded | bus.qWr) & ~bus.qRd;
  end

  // Grant search starts at rr (always 0 in fixed-priority builds).
  always_comb begin
    gnt_ok = 1'b0;
    gnt    = '0;
    gidx   = '0;
    for (int k = 0; k < NQ; k++) begin
      gidx = QW'((int'(rr) + k) % NQ);
      if (!gnt_ok && !bus.qEmpty[gidx]) begin
        gnt_ok = 1'b1;
        gnt    = gidx;
      end
    end
  end

`ifdef RING_MEM_SCHED_RR_EN
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB)
      rr <= '0;
    else if (state == DRAIN && gnt_ok)
      rr <= (int'(gnt) == NQ - 1) ? '0 : gnt + 1'b1;
  end
`else
  assign rr = '0;
`endif

  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:       if (go) state <= SEND_TOKEN;
        SEND_TOKEN: state <= WAIT_TOKEN;
        WAIT_TOKEN: if (bus.slotTypeIn == SLOT_TOKEN) state <= WAIT_DATA;
        WAIT_DATA:
          if (burst_cnt == '0) begin
            if (|loaded)              state <= WAIT_Q;
            else if (!(&bus.qEmpty))  state <= DRAIN;
            else if (go)              state <= SEND_TOKEN;
            else                      state <= IDLE;
          end
        WAIT_Q:     if (&(~loaded | ~bus.qEmpty)) state <= DRAIN;
        DRAIN:      if (!gnt_ok) state <= go ? SEND_TOKEN : IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Slot injection is combinational so a grant goes out the same cycle.
  always_comb begin
    bus.slotTypeOut = SLOT_NULL;
    bus.ringOut     = '0;
    bus.srcDestOut  = '0;
    bus.qRd         = '0;
    head            = bus.qData[int'(gnt)*EW +: EW];
    case (state)
      SEND_TOKEN: bus.slotTypeOut = SLOT_TOKEN;
      DRAIN:
        if (gnt_ok) begin
          bus.qRd[gnt]    = 1'b1;
          bus.ringOut     = head[W-1:0];
          bus.slotTypeOut = remap_type(head[W+3:W], REMAP_MASK[gnt]);
          bus.srcDestOut  = head[W+7:W+4];
        end
      default: ;
    endcase
  end

  ring_wd_assembler #(.W(W), .WPL(WPL), .WDQ_DEPTH(WDQ_DEPTH)) u_wd (
    .clock      (clock),
    .resetB     (resetB),
    .word_valid (bus.slotTypeIn == SLOT_WDATA),
    .word       (bus.ringIn),
    .wd_rd      (bus.wdRd),
    .wd_wr      (bus.wdWr),
    .wd_data    (bus.wdData),
    .wdq_count  (bus.wdqCount)
  );

  assign bus.wdqAlmostFull = (int'(bus.wdqCount) > WDQ_THRESH);

endmodule

// File: tb/tb_ring_mem_sched.sv
// Directed bench for ring_mem_sched: a vector table for the token/burst
// cycle, then hand-written sequences for queue latency, drain order,
// line assembly, almost-full back-pressure and mid-drain reset.
module tb_ring_mem_sched;
  import ring_pkg::*;

  localparam int W = 32, NQ = 2, WPL = 4, DEPTH = 1024, EW = W + 8;

  logic clock = 1'b0;
  logic resetB;
  always #5 clock = ~clock;

  ring_mem_sched_if #(.W(W), .NQ(NQ), .WPL(WPL), .WDQ_DEPTH(DEPTH)) bus ();

  // Queue 1 remaps Address->AddressRequest, queue 0 passes type 2 through.
  ring_mem_sched #(.W(W), .NQ(NQ), .WPL(WPL), .WDQ_DEPTH(DEPTH),
                   .WDQ_THRESH(900), .REMAP_MASK(2'b10)) dut (
    .clock (clock), .resetB (resetB), .bus (bus.slave));

  int n_tests = 0, n_fail = 0;
  logic [EW-1:0] fq[NQ][$];   // external drain FIFO contents

  typedef struct {
    logic       inh;
    logic [3:0] st;
    logic [W-1:0] d;
    logic [3:0] est;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] st, input logic [W-1:0] d,
                         input logic [3:0] sd, input logic [NQ-1:0] rd);
    chk(nm, {bus.srcDestOut, bus.slotTypeOut, bus.ringOut, bus.qRd}, {sd, st, d, rd});
  endtask

  // Present ring slot and FIFO heads, then wait to the sampling point.
  task automatic drive(input logic [3:0] st, input logic [W-1:0] d);
    bus.slotTypeIn = st;
    bus.ringIn     = d;
    for (int i = 0; i < NQ; i++) begin
      bus.qEmpty[i]           = (fq[i].size() == 0);
      bus.qData[i*EW +: EW]   = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
    @(negedge clock);
  endtask

  task automatic adv();
    logic [NQ-1:0] rd;
    rd = bus.qRd;
    @(posedge clock);
    #1;
    for (int i = 0; i < NQ; i++)
      if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    bus.qWr  = '0;
    bus.wdRd = 1'b0;
  endtask

  function automatic logic [EW-1:0] ent(input logic [3:0] dst, input logic [3:0] t,
                                        input logic [W-1:0] d);
    return {dst, t, d};
  endfunction

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [EW-1:0] e_exp[4];
    logic [NQ-1:0] r_exp[4];
    logic [W-1:0]  wd[8];

    // token / burst cycle: {inhibit, slotTypeIn, ringIn, expected slotTypeOut}
    tbl[0]  = '{1'b1, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[1]  = '{1'b1, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[2]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[3]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_TOKEN};
    tbl[4]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[5]  = '{1'b0, SLOT_TOKEN, 32'd3, SLOT_NULL};
    tbl[6]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[7]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[8]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[9]  = '{1'b0, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[10] = '{1'b0, SLOT_NULL,  32'd0, SLOT_TOKEN};
    tbl[11] = '{1'b0, SLOT_TOKEN, 32'd0, SLOT_NULL};
    tbl[12] = '{1'b1, SLOT_NULL,  32'd0, SLOT_NULL};
    tbl[13] = '{1'b1, SLOT_NULL,  32'd0, SLOT_NULL};

    resetB = 1'b0;
    bus.ringIn = '0; bus.slotTypeIn = SLOT_NULL; bus.srcDestIn = '0;
    bus.inhibit = 1'b1; bus.qEmpty = '1; bus.qWr = '0; bus.qData = '0; bus.wdRd = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_out("reset_out", SLOT_NULL, '0, '0, '0);
    chk("reset_wd", {bus.wdWr, bus.wdqCount, bus.wdqAlmostFull}, '0);
    chk("reset_wddata", bus.wdData, '0);
    resetB = 1'b1;

    foreach (tbl[k]) begin
      bus.inhibit = tbl[k].inh;
      drive(tbl[k].st, tbl[k].d);
      chk_out($sformatf("vec%0d", k), tbl[k].est, '0, '0, '0);
      adv();
    end

    // queue written during burst, FIFO shows it two cycles later
    bus.inhibit = 1'b0;
    drive(SLOT_NULL, 0);     chk_out("q_idle", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);     chk_out("q_tok", SLOT_TOKEN, '0, '0, '0); adv();
    drive(SLOT_TOKEN, 1);    chk_out("q_wtok", SLOT_NULL, '0, '0, '0); adv();
    bus.qWr = 2'b10;
    drive(SLOT_NULL, 0);     chk_out("q_burst", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);     chk_out("q_wdata0", SLOT_NULL, '0, '0, '0); adv();
    fq[1].push_back(ent(4'hA, SLOT_ADDR, 32'h1234_5678));
    drive(SLOT_NULL, 0);     chk_out("q_waitq", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);     chk_out("q_remap", SLOT_AREQ, 32'h1234_5678, 4'hA, 2'b10); adv();
    drive(SLOT_NULL, 0);     chk_out("q_empty", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);     chk_out("q_retok", SLOT_TOKEN, '0, '0, '0); adv();

    // drain order with two entries in each queue
    fq[0].push_back(ent(4'h1, SLOT_ADDR,  32'hA0));
    fq[0].push_back(ent(4'h1, SLOT_ADDR,  32'hA1));
    fq[1].push_back(ent(4'h2, SLOT_WDATA, 32'hB0));
    fq[1].push_back(ent(4'h2, SLOT_WDATA, 32'hB1));
`ifdef RING_MEM_SCHED_RR_EN
    e_exp = '{ent(4'h1, SLOT_ADDR, 32'hA0), ent(4'h2, SLOT_WDATA, 32'hB0),
              ent(4'h1, SLOT_ADDR, 32'hA1), ent(4'h2, SLOT_WDATA, 32'hB1)};
    r_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    e_exp = '{ent(4'h1, SLOT_ADDR, 32'hA0), ent(4'h1, SLOT_ADDR, 32'hA1),
              ent(4'h2, SLOT_WDATA, 32'hB0), ent(4'h2, SLOT_WDATA, 32'hB1)};
    r_exp = '{2'b01, 2'b01, 2'b10, 2'b10};
`endif
    drive(SLOT_TOKEN, 0);    chk_out("d_wtok", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);     chk_out("d_wdata", SLOT_NULL, '0, '0, '0); adv();
    for (int k = 0; k < 4; k++) begin
      drive(SLOT_NULL, 0);
      chk_out($sformatf("d_grant%0d", k), e_exp[k][W+3:W], e_exp[k][W-1:0],
              e_exp[k][W+7:W+4], r_exp[k]);
      adv();
    end
    drive(SLOT_NULL, 0);     chk_out("d_done", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);     chk_out("d_retok", SLOT_TOKEN, '0, '0, '0); adv();

    // line assembly: 8 words -> two lines
    for (int k = 0; k < 8; k++) wd[k] = 32'h1111_1111 * (k + 1);
    for (int k = 0; k < 8; k++) begin
      drive(SLOT_WDATA, wd[k]);
      chk($sformatf("wd_wr%0d", k), bus.wdWr, (k == 4));
      if (k == 4) begin
        chk("wd_line0", bus.wdData, {wd[3], wd[2], wd[1], wd[0]});
        chk("wd_cnt0", bus.wdqCount, 0);
      end
      if (k == 5) chk("wd_cnt1", bus.wdqCount, 1);
      adv();
    end
    drive(SLOT_NULL, 0);
    chk("wd_wr8", bus.wdWr, 1);
    chk("wd_line1", bus.wdData, {wd[7], wd[6], wd[5], wd[4]});
    adv();
    drive(SLOT_NULL, 0);
    chk("wd_cnt2", {bus.wdWr, bus.wdqCount}, {1'b0, 11'd2});
    adv();

    // fill to 901 lines, then back-pressure blocks the token
    for (int k = 0; k < 899 * WPL; k++) begin
      drive(SLOT_WDATA, k);
      adv();
    end
    drive(SLOT_TOKEN, 0);    chk("af_lastpush", bus.wdWr, 1); adv();
    drive(SLOT_NULL, 0);
    chk("af_cnt901", {bus.wdqAlmostFull, bus.wdqCount}, {1'b1, 11'd901});
    adv();
    drive(SLOT_NULL, 0);     chk_out("af_idle", SLOT_NULL, '0, '0, '0); adv();
    bus.wdRd = 1'b1;
    drive(SLOT_NULL, 0);     chk_out("af_pop", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_NULL, 0);
    chk("af_cnt900", {bus.wdqAlmostFull, bus.wdqCount}, {1'b0, 11'd900});
    chk_out("af_release", SLOT_NULL, '0, '0, '0);
    adv();
    drive(SLOT_NULL, 0);     chk_out("af_tok", SLOT_TOKEN, '0, '0, '0); adv();

    // reset mid-drain with a partial line pending
    for (int k = 0; k < 3; k++) fq[0].push_back(ent(4'h5, SLOT_WDATA, 32'hC0 + k));
    drive(SLOT_TOKEN, 0);              chk_out("r_wtok", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_WDATA, 32'hDEAD_0001);  chk_out("r_wdata", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_WDATA, 32'hDEAD_0002);  chk_out("r_g0", SLOT_WDATA, 32'hC0, 4'h5, 2'b01); adv();
    drive(SLOT_NULL, 0);               chk_out("r_g1", SLOT_WDATA, 32'hC1, 4'h5, 2'b01);
    resetB = 1'b0;
    #1;
    chk_out("r_asserted", SLOT_NULL, '0, '0, '0);
    chk("r_cnt", bus.wdqCount, 0);
    adv();
    resetB = 1'b1;
    chk("r_fifo_left", fq[0].size(), 2);
    drive(SLOT_WDATA, 32'hCAFE_0001);  chk_out("r_idle", SLOT_NULL, '0, '0, '0); adv();
    drive(SLOT_WDATA, 32'hCAFE_0002);  chk_out("r_tok", SLOT_TOKEN, '0, '0, '0); adv();
    drive(SLOT_WDATA, 32'hCAFE_0003);  adv();
    drive(SLOT_WDATA, 32'hCAFE_0004);  chk("r_nopush", bus.wdWr, 0); adv();
    drive(SLOT_NULL, 0);
    chk("r_push", bus.wdWr, 1);
    chk("r_line", bus.wdData, {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001});
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
